// File: rtl/sr_frame_serializer_if.sv
// Handshake and data bundle between the register file, the frame serializer
// and the off-chip shift-register chain.
interface sr_frame_serializer_if #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16
);
  logic                  sel_stat;
  logic                  sel_dyn;
  logic                  lsb_first;
  logic                  start;
  logic [SIZESRSTAT-1:0] stat_reg;
  logic [SIZESRDYN-1:0]  dyn_reg;
  logic [SIZESRSTAT-1:0] stat_latch;
  logic [SIZESRDYN-1:0]  dyn_latch;
  logic                  sr_data;
  logic                  sr_clk;
  logic                  sr_load;
  logic                  busy;
  logic                  done;

  // Requester side: drives the frame request and word sources.
  modport master (
    output sel_stat, sel_dyn, lsb_first, start, stat_reg, dyn_reg,
    input  stat_latch, dyn_latch, sr_data, sr_clk, sr_load, busy, done
  );

  // Serializer side.
  modport slave (
    input  sel_stat, sel_dyn, lsb_first, start, stat_reg, dyn_reg,
    output stat_latch, dyn_latch, sr_data, sr_clk, sr_load, busy, done
  );
endinterface

// File: rtl/sr_frame_serializer.sv
// Frame serializer: captures the static and/or dynamic word on an accepted
// START and shifts the frame out as data / shift clock / load strobe, each
// half-period lasting DIV system clocks. All outputs come straight from flops.
module sr_frame_serializer #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int DIV        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_frame_serializer_if.slave  bus
);

  localparam int TOT = SIZESRSTAT + SIZESRDYN;
  localparam int CW  = $clog2(TOT + 1);
  localparam int DW  = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    FIN
  } state_t;

  state_t                state, state_n;
  logic [DW-1:0]         div_cnt, div_n;
  logic [CW-1:0]         bit_cnt, bit_n;
  logic [CW-1:0]         frame_len, len_n;
  logic [TOT-1:0]        shifter, shift_n;
  logic [SIZESRSTAT-1:0] stat_latch_q, stat_latch_n;
  logic [SIZESRDYN-1:0]  dyn_latch_q, dyn_latch_n;
  logic                  sr_data_q, sr_data_n;
  logic                  sr_clk_q, sr_clk_n;
  logic                  sr_load_q, sr_load_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;

  logic [SIZESRSTAT-1:0] stat_ord;
  logic [SIZESRDYN-1:0]  dyn_ord;
  logic [TOT-1:0]        frame;

  function automatic logic [SIZESRSTAT-1:0] rev_stat(input logic [SIZESRSTAT-1:0] v);
    logic [SIZESRSTAT-1:0] r;
    for (int i = 0; i < SIZESRSTAT; i++) r[i] = v[SIZESRSTAT-1-i];
    return r;
  endfunction

  function automatic logic [SIZESRDYN-1:0] rev_dyn(input logic [SIZESRDYN-1:0] v);
    logic [SIZESRDYN-1:0] r;
    for (int i = 0; i < SIZESRDYN; i++) r[i] = v[SIZESRDYN-1-i];
    return r;
  endfunction

  // State, counters, shifter, latches and output flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_len    <= '0;
      // NOTE: the shifter is ordinary flops, not a RAM, so it is reset like
      // everything else; a reset mid-frame leaves no stale bits behind.
      shifter      <= '0;
      stat_latch_q <= '0;
      dyn_latch_q  <= '0;
      sr_data_q    <= 1'b0;
      sr_clk_q     <= 1'b0;
      sr_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_n;
      bit_cnt      <= bit_n;
      frame_len    <= len_n;
      shifter      <= shift_n;
      stat_latch_q <= stat_latch_n;
      dyn_latch_q  <= dyn_latch_n;
      sr_data_q    <= sr_data_n;
      sr_clk_q     <= sr_clk_n;
      sr_load_q    <= sr_load_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
    end
  end

  // Next state plus next values of every output flop, derived from the state
  // being entered so outputs line up with the state register.
  always_comb begin
    // NOTE: every variable gets a default first; a missed branch would
    // otherwise infer a latch.
    state_n      = state;
    div_n        = div_cnt;
    bit_n        = bit_cnt;
    len_n        = frame_len;
    shift_n      = shifter;
    stat_latch_n = stat_latch_q;
    dyn_latch_n  = dyn_latch_q;
    sr_data_n    = 1'b0;
    sr_clk_n     = 1'b0;
    sr_load_n    = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;

    // Each word is bit-reversed on its own when LSB-first is requested, then
    // the frame is packed so it always leaves from the shifter's MSB.
    stat_ord = bus.lsb_first ? rev_stat(bus.stat_reg) : bus.stat_reg;
    dyn_ord  = bus.lsb_first ? rev_dyn(bus.dyn_reg) : bus.dyn_reg;
    frame    = bus.sel_stat ? {stat_ord, dyn_ord} : {dyn_ord, {SIZESRSTAT{1'b0}}};

    case (state)
      IDLE: begin
        if (bus.start && (bus.sel_stat || bus.sel_dyn)) begin
          if (bus.sel_stat) stat_latch_n = bus.stat_reg;
          if (bus.sel_dyn)  dyn_latch_n  = bus.dyn_reg;
          shift_n   = frame;
          len_n     = (bus.sel_stat ? CW'(SIZESRSTAT) : CW'(0)) +
                      (bus.sel_dyn  ? CW'(SIZESRDYN)  : CW'(0));
          div_n     = '0;
          bit_n     = '0;
          state_n   = SHIFT_LO;
          busy_n    = 1'b1;
          sr_data_n = frame[TOT-1];
        end
      end

      SHIFT_LO: begin
        busy_n    = 1'b1;
        sr_data_n = shifter[TOT-1];
        if (div_cnt == DIV_LAST) begin
          div_n    = '0;
          state_n  = SHIFT_HI;
          sr_clk_n = 1'b1;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end

      SHIFT_HI: begin
        busy_n    = 1'b1;
        sr_data_n = shifter[TOT-1];
        sr_clk_n  = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_n    = '0;
          bit_n    = bit_cnt + CW'(1);
          sr_clk_n = 1'b0;
          if ((bit_cnt + CW'(1)) == frame_len) begin
            state_n   = LOAD;
            sr_data_n = 1'b0;
            sr_load_n = 1'b1;
          end else begin
            shift_n   = {shifter[TOT-2:0], 1'b0};
            sr_data_n = shifter[TOT-2];
            state_n   = SHIFT_LO;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end

      LOAD: begin
        busy_n    = 1'b1;
        sr_load_n = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_n     = '0;
          state_n   = FIN;
          busy_n    = 1'b0;
          sr_load_n = 1'b0;
          done_n    = 1'b1;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.stat_latch = stat_latch_q;
  assign bus.dyn_latch  = dyn_latch_q;
  assign bus.sr_data    = sr_data_q;
  assign bus.sr_clk     = sr_clk_q;
  assign bus.sr_load    = sr_load_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sr_frame_serializer.sv
// Directed bench for sr_frame_serializer (88/16 bits, DIV=2).
module tb_sr_frame_serializer;

  localparam logic [87:0] STAT1 = 88'h123456789ABCDEF1234567;
  localparam logic [87:0] STAT2 = 88'hA1B2C3D4E5F67890ABCDE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sr_frame_serializer_if #(.SIZESRSTAT(88), .SIZESRDYN(16)) bus ();

  sr_frame_serializer #(.SIZESRSTAT(88), .SIZESRDYN(16), .DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Passive monitor: samples on the falling edge, away from DUT updates.
  logic [103:0] mon_bits;
  int mon_nbits, mon_busy, mon_load, mon_done, mon_overlap, mon_clkhi;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    if (bus.busy) mon_busy++;
    if (bus.sr_load) mon_load++;
    if (bus.done) mon_done++;
    if (bus.busy && bus.done) mon_overlap++;
    if (bus.sr_clk) mon_clkhi++;
    if (bus.sr_clk && !prev_clk) begin
      mon_bits = {mon_bits[102:0], bus.sr_data};
      mon_nbits++;
    end
    prev_clk = bus.sr_clk;
  end

  task automatic clear_mon();
    mon_bits = '0; mon_nbits = 0; mon_busy = 0; mon_load = 0;
    mon_done = 0; mon_overlap = 0; mon_clkhi = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; clear_mon(); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s_timeout got=no_done exp=done within %0d", name, limit); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.sel_stat = 1'b1; bus.sel_dyn = 1'b1; bus.lsb_first = 1'b0;
    bus.stat_reg = {$urandom, $urandom, $urandom};
    bus.dyn_reg = 16'($urandom);
    repeat (3) @(negedge clk);
    total++;
    if ({bus.stat_latch, bus.dyn_latch, bus.sr_data, bus.sr_clk, bus.sr_load, bus.busy, bus.done} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b clk=%b load=%b done=%b exp=all 0",
                      bus.busy, bus.sr_clk, bus.sr_load, bus.done);
    end
    @(posedge clk); #1; bus.start = 1'b0; rst = 1'b0; clear_mon();
    repeat (20) @(negedge clk);
    total++;
    if (mon_busy + mon_clkhi + mon_load + mon_done !== 0) begin
      bad++; $display("FAIL reset_idle got busy=%0d clkhi=%0d load=%0d done=%0d exp=0",
                      mon_busy, mon_clkhi, mon_load, mon_done);
    end
  endtask

  task automatic test_static_msb();
    bus.sel_stat = 1'b1; bus.sel_dyn = 1'b0; bus.lsb_first = 1'b0;
    bus.stat_reg = STAT1; bus.dyn_reg = 16'h0000;
    pulse_start();
    @(negedge clk);
    total++;
    if (!(bus.busy === 1'b1 && bus.sr_clk === 1'b0 && bus.sr_data === 1'b0 && bus.stat_latch === STAT1)) begin
      bad++; $display("FAIL stat_first_cycle got busy=%b clk=%b data=%b latch=%h exp=1 0 0 %h",
                      bus.busy, bus.sr_clk, bus.sr_data, bus.stat_latch, STAT1);
    end
    wait_done(1000, "stat");
    total++;
    if (mon_nbits !== 88 || mon_bits[87:0] !== STAT1) begin
      bad++; $display("FAIL stat_bits got n=%0d val=%h exp=88 %h", mon_nbits, mon_bits[87:0], STAT1);
    end
    total++;
    if (mon_bits[87:84] !== 4'b0001) begin
      bad++; $display("FAIL stat_first_bits got=%b exp=0001", mon_bits[87:84]);
    end
    total++;
    if (mon_busy !== 354 || mon_load !== 2 || mon_done !== 1 || mon_overlap !== 0) begin
      bad++; $display("FAIL stat_timing got busy=%0d load=%0d done=%0d ovl=%0d exp=354 2 1 0",
                      mon_busy, mon_load, mon_done, mon_overlap);
    end
  endtask

  task automatic test_dyn_lsb();
    logic [15:0] recon;
    bus.sel_stat = 1'b0; bus.sel_dyn = 1'b1; bus.lsb_first = 1'b1;
    bus.dyn_reg = 16'hABCD; bus.stat_reg = STAT2;
    pulse_start();
    wait_done(300, "dyn");
    for (int i = 0; i < 16; i++) recon[i] = mon_bits[15-i];
    total++;
    if (mon_bits[15:12] !== 4'b1011) begin
      bad++; $display("FAIL dyn_first_bits got=%b exp=1011", mon_bits[15:12]);
    end
    total++;
    if (mon_nbits !== 16 || recon !== 16'hABCD) begin
      bad++; $display("FAIL dyn_bits got n=%0d val=%h exp=16 abcd", mon_nbits, recon);
    end
    total++;
    if (mon_busy !== 66 || mon_done !== 1) begin
      bad++; $display("FAIL dyn_timing got busy=%0d done=%0d exp=66 1", mon_busy, mon_done);
    end
    total++;
    if (bus.stat_latch !== STAT1 || bus.dyn_latch !== 16'hABCD) begin
      bad++; $display("FAIL dyn_latches got stat=%h dyn=%h exp=%h abcd", bus.stat_latch, bus.dyn_latch, STAT1);
    end
  endtask

  task automatic test_concat();
    bus.sel_stat = 1'b1; bus.sel_dyn = 1'b1; bus.lsb_first = 1'b0;
    bus.stat_reg = STAT1; bus.dyn_reg = 16'hABCD;
    pulse_start();
    repeat (100) @(negedge clk);
    @(posedge clk); #1;
    bus.dyn_reg = 16'h5678; bus.stat_reg = STAT2; bus.sel_stat = 1'b0; bus.lsb_first = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done(1000, "concat");
    repeat (10) @(negedge clk);
    total++;
    if (mon_nbits !== 104 || mon_bits !== {STAT1, 16'hABCD}) begin
      bad++; $display("FAIL concat_bits got n=%0d val=%h exp=104 %h", mon_nbits, mon_bits, {STAT1, 16'hABCD});
    end
    total++;
    if (mon_busy !== 418 || mon_done !== 1 || mon_load !== 2) begin
      bad++; $display("FAIL concat_timing got busy=%0d done=%0d load=%0d exp=418 1 2", mon_busy, mon_done, mon_load);
    end
    total++;
    if (bus.stat_latch !== STAT1 || bus.dyn_latch !== 16'hABCD) begin
      bad++; $display("FAIL concat_latches got stat=%h dyn=%h exp=%h abcd", bus.stat_latch, bus.dyn_latch, STAT1);
    end
  endtask

  task automatic test_no_sel();
    @(posedge clk); #1; clear_mon();
    bus.sel_stat = 1'b0; bus.sel_dyn = 1'b0; bus.stat_reg = STAT2; bus.dyn_reg = 16'h1111; bus.start = 1'b1;
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mon_busy + mon_clkhi + mon_load + mon_done !== 0) begin
      bad++; $display("FAIL nosel_activity got busy=%0d clkhi=%0d load=%0d done=%0d exp=0",
                      mon_busy, mon_clkhi, mon_load, mon_done);
    end
    total++;
    if (bus.stat_latch !== STAT1 || bus.dyn_latch !== 16'hABCD) begin
      bad++; $display("FAIL nosel_latches got stat=%h dyn=%h exp=%h abcd", bus.stat_latch, bus.dyn_latch, STAT1);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0, r1 = -1, r2 = -1;
    logic prev = 1'b0;
    bus.sel_stat = 1'b0; bus.sel_dyn = 1'b1; bus.lsb_first = 1'b0; bus.dyn_reg = 16'h00FF;
    @(posedge clk); #1; clear_mon(); bus.start = 1'b1;
    for (int i = 0; i < 300 && r2 < 0; i++) begin
      @(negedge clk);
      if (bus.busy && !prev) begin
        if (r1 < 0) r1 = t; else r2 = t;
      end
      prev = bus.busy;
      t++;
    end
    bus.start = 1'b0;
    total++;
    if (r2 - r1 !== 68) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=68", r2 - r1);
    end
    wait_done(300, "b2b");
    total++;
    if (mon_done !== 2 || mon_overlap !== 0 || mon_nbits !== 32 || mon_bits[31:0] !== 32'h00FF00FF) begin
      bad++; $display("FAIL b2b_frames got done=%0d ovl=%0d n=%0d bits=%h exp=2 0 32 00ff00ff",
                      mon_done, mon_overlap, mon_nbits, mon_bits[31:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit reached = 1'b0;
    bus.sel_stat = 1'b1; bus.sel_dyn = 1'b0; bus.lsb_first = 1'b0; bus.stat_reg = STAT2;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mon_nbits == 40) begin reached = 1'b1; break; end
    end
    total++;
    if (!reached) begin bad++; $display("FAIL midrst_bit40_timeout got n=%0d exp=40", mon_nbits); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.stat_latch, bus.dyn_latch, bus.sr_data, bus.sr_clk, bus.sr_load, bus.busy, bus.done} !== '0) begin
      bad++; $display("FAIL midrst_async got busy=%b clk=%b load=%b exp=all 0", bus.busy, bus.sr_clk, bus.sr_load);
    end
    repeat (3) @(negedge clk);
    total++;
    if (mon_load !== 0 || mon_done !== 0) begin
      bad++; $display("FAIL midrst_no_load got load=%0d done=%0d exp=0 0", mon_load, mon_done);
    end
    @(posedge clk); #1; rst = 1'b0;
    bus.sel_stat = 1'b0; bus.sel_dyn = 1'b1; bus.dyn_reg = 16'h5678;
    pulse_start();
    wait_done(300, "midrst");
    total++;
    if (mon_nbits !== 16 || mon_bits[15:0] !== 16'h5678 || mon_busy !== 66 || mon_done !== 1) begin
      bad++; $display("FAIL midrst_refrm got n=%0d val=%h busy=%0d done=%0d exp=16 5678 66 1",
                      mon_nbits, mon_bits[15:0], mon_busy, mon_done);
    end
    total++;
    if (bus.stat_latch !== 88'h0 || bus.dyn_latch !== 16'h5678) begin
      bad++; $display("FAIL midrst_latches got stat=%h dyn=%h exp=0 5678", bus.stat_latch, bus.dyn_latch);
    end
  endtask

  initial begin
    clear_mon();
    bus.start = 1'b0; bus.sel_stat = 1'b0; bus.sel_dyn = 1'b0; bus.lsb_first = 1'b0;
    bus.stat_reg = '0; bus.dyn_reg = '0;
    test_reset();
    test_static_msb();
    test_dyn_lsb();
    test_concat();
    test_no_sel();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
